// File: rtl/data_arbiter.sv
// Store write buffer plus round-robin load channels sharing ramctrl's single data port.
// Optional macro LD_BYPASS_EN: loads overtake buffered stores to different words.
module data_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_LD   = 2,
    parameter int SQ_DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       rob_rst_in,
    input  logic                       rob_st_en_in,
    input  logic [2:0]                 rob_st_width_in,
    input  logic [ADDR_W-1:0]          rob_st_addr_in,
    input  logic [DATA_W-1:0]          rob_st_data_in,
    output logic                       st_full_out,
    output logic                       st_ack_out,
    input  logic [NUM_LD-1:0]          ld_en_in,
    input  logic [NUM_LD*ADDR_W-1:0]   ld_addr_in,
    input  logic [NUM_LD*3-1:0]        ld_width_in,
    input  logic [NUM_LD-1:0]          ld_sgn_in,
    output logic [NUM_LD-1:0]          ld_done_out,
    output logic [DATA_W-1:0]          ld_data_out,
    output logic                       ram_en_out,
    output logic                       ram_rw_out,
    output logic                       ram_sgn_out,
    output logic [2:0]                 ram_width_out,
    output logic [ADDR_W-1:0]          ram_addr_out,
    output logic [DATA_W-1:0]          ram_data_out,
    input  logic                       ram_rdy_in,
    input  logic [DATA_W-1:0]          ram_data_in
);
    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, OK} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] sq_addr  [SQ_DEPTH];
    logic [DATA_W-1:0] sq_data  [SQ_DEPTH];
    logic [2:0]        sq_width [SQ_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [RR_W-1:0]   rr_ptr, gnt, ld_pick;
    logic [NUM_LD-1:0] ld_req;
    logic              full, empty, push, pop, flush, ld_any, take_st, take_ld;

    assign full        = (count == CNT_W'(SQ_DEPTH));
    assign empty       = (count == '0);
    assign st_full_out = full || !rdy_in;
    assign push        = rdy_in && rob_st_en_in && !full;
    assign pop         = rdy_in && (state == WDATA) && ram_rdy_in;
    assign flush       = rdy_in && rob_rst_in;

`ifdef LD_BYPASS_EN
    // A load touching a word still sitting in the buffer must wait for it to drain.
    always_comb begin
        ld_req = ld_en_in;
        for (int c = 0; c < NUM_LD; c++) begin
            for (int e = 0; e < SQ_DEPTH; e++) begin
                if ({1'b0, PTR_W'(e) - head} < count &&
                    sq_addr[e][ADDR_W-1:2] == ld_addr_in[c*ADDR_W+2 +: ADDR_W-2])
                    ld_req[c] = 1'b0;
            end
        end
    end
    assign take_st = !empty && (full || !ld_any || flush);
`else
    assign ld_req  = ld_en_in;
    assign take_st = !empty;
`endif
    assign take_ld = !take_st && ld_any && !flush;

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        ld_any  = 1'b0;
        ld_pick = '0;
        for (int k = NUM_LD - 1; k >= 0; k--) begin
            if (ld_req[(int'(rr_ptr) + k) % NUM_LD]) begin
                ld_any  = 1'b1;
                ld_pick = RR_W'((int'(rr_ptr) + k) % NUM_LD);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take_st) state_nx = WDATA;
                     else if (take_ld) state_nx = RDATA;
            RDATA:   if (flush) state_nx = IDLE;
                     else if (ram_rdy_in) state_nx = OK;
            WDATA:   if (ram_rdy_in) state_nx = OK;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            sq_addr[tail]  <= rob_st_addr_in;
            sq_data[tail]  <= rob_st_data_in;
            sq_width[tail] <= rob_st_width_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rr_ptr        <= '0;
            gnt           <= '0;
            st_ack_out    <= 1'b0;
            ld_done_out   <= '0;
            ld_data_out   <= '0;
            ram_en_out    <= 1'b0;
            ram_rw_out    <= 1'b0;
            ram_sgn_out   <= 1'b0;
            ram_width_out <= '0;
            ram_addr_out  <= '0;
            ram_data_out  <= '0;
        end else if (rdy_in) begin
            state      <= state_nx;
            st_ack_out <= push;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (state == OK || flush) ld_done_out <= '0;
            case (state)
                IDLE: begin
                    if (take_st) begin
                        ram_en_out    <= 1'b1;
                        ram_rw_out    <= 1'b1;
                        ram_sgn_out   <= 1'b0;
                        ram_width_out <= sq_width[head];
                        ram_addr_out  <= sq_addr[head];
                        ram_data_out  <= sq_data[head];
                    end else if (take_ld) begin
                        ram_en_out    <= 1'b1;
                        ram_rw_out    <= 1'b0;
                        ram_sgn_out   <= ld_sgn_in[ld_pick];
                        ram_width_out <= ld_width_in[int'(ld_pick)*3 +: 3];
                        ram_addr_out  <= ld_addr_in[int'(ld_pick)*ADDR_W +: ADDR_W];
                        ram_data_out  <= '0;
                        gnt           <= ld_pick;
                        rr_ptr        <= (int'(ld_pick) == NUM_LD - 1) ? '0 : ld_pick + 1'b1;
                    end
                end
                RDATA: begin
                    // A flush abandons the read; the result is never delivered.
                    if (flush) begin
                        ram_en_out <= 1'b0;
                    end else if (ram_rdy_in) begin
                        ram_en_out       <= 1'b0;
                        ld_data_out      <= ram_data_in;
                        ld_done_out[gnt] <= 1'b1;
                    end
                end
                WDATA: if (ram_rdy_in) ram_en_out <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_arbiter.sv
// Self-checking bench for data_arbiter: vector table, directed corner sequences, randomized phases.
module tb_data_arbiter;
    localparam int AW = 32, DW = 32, NL = 2, SD = 4;

    logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, rob_rst = 1'b0, st_en = 1'b0;
    logic [2:0] st_width = '0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic st_full, st_ack;
    logic [NL-1:0] ld_en = '0, ld_sgn = '0, ld_done;
    logic [NL*AW-1:0] ld_addr = '0;
    logic [NL*3-1:0] ld_width = '0;
    logic [DW-1:0] ld_data;
    logic ram_en, ram_rw, ram_sgn;
    logic [2:0] ram_width;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic ram_rdy = 1'b0;
    logic [DW-1:0] ram_rdata = '0;

    data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_LD(NL), .SQ_DEPTH(SD)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .rob_rst_in(rob_rst),
        .rob_st_en_in(st_en), .rob_st_width_in(st_width), .rob_st_addr_in(st_addr),
        .rob_st_data_in(st_data), .st_full_out(st_full), .st_ack_out(st_ack),
        .ld_en_in(ld_en), .ld_addr_in(ld_addr), .ld_width_in(ld_width), .ld_sgn_in(ld_sgn),
        .ld_done_out(ld_done), .ld_data_out(ld_data),
        .ram_en_out(ram_en), .ram_rw_out(ram_rw), .ram_sgn_out(ram_sgn),
        .ram_width_out(ram_width), .ram_addr_out(ram_addr), .ram_data_out(ram_data),
        .ram_rdy_in(ram_rdy), .ram_data_in(ram_rdata)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    typedef struct {
        logic rw; logic [31:0] addr; logic [31:0] data; logic [2:0] width; logic sgn; logic stable;
    } txn_t;

    typedef struct {
        bit st; int ch; logic [31:0] addr; logic [2:0] width; logic sgn; bit plant;
        logic [31:0] data; logic exp_rw; logic [31:0] exp_addr; logic [31:0] exp_data;
    } vec_t;

    logic [31:0] mem [256];
    logic [31:0] refm [256];
    txn_t log_q[$];
    logic [63:0] exp_wr[$];
    vec_t vt[6];
    bit resp_on = 1'b1;
    int lat = 0;
    int rr_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ramctrl stand-in: completes each transaction lat cycles after it first sees ram_en.
    initial begin
        txn_t cur;
        bit active;
        int cnt;
        active = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            ram_rdy = 1'b0;
            if (ram_en === 1'b1) begin
                if (!active) begin
                    cur = '{ram_rw, ram_addr, ram_data, ram_width, ram_sgn, 1'b1};
                    active = 1'b1;
                    cnt = 0;
                end else if ({ram_rw, ram_addr, ram_data, ram_width, ram_sgn} !==
                             {cur.rw, cur.addr, cur.data, cur.width, cur.sgn}) begin
                    cur.stable = 1'b0;
                end
                if (resp_on) begin
                    if (cnt >= lat) begin
                        ram_rdy = 1'b1;
                        if (cur.rw) mem[cur.addr[9:2]] = cur.data;
                        else begin
                            ram_rdata = mem[cur.addr[9:2]];
                            cur.data = ram_rdata;
                        end
                        log_q.push_back(cur);
                        active = 1'b0;
                    end else cnt++;
                end
            end else active = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ld_done !== '0) chk("done_onehot", $onehot(ld_done), 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
        int k;
        k = 0;
        @(negedge clk);
        st_addr = a; st_data = d; st_width = w; st_en = 1'b1;
        while (st_full && k < 100) begin @(negedge clk); k++; end
        chk("store_accept", k < 100, 1);
        refm[a[9:2]] = d;
        exp_wr.push_back({a, d});
        @(negedge clk);
        st_en = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < 300) begin @(negedge clk); k++; end
        chk(name, log_q.size() >= n, 1);
    endtask

    task automatic wait_en(input logic rw, input string name);
        int k;
        k = 0;
        while (!(ram_en === 1'b1 && ram_rw === rw) && k < 100) begin @(negedge clk); k++; end
        chk(name, k < 100, 1);
    endtask

    task automatic set_ld(input int ch, input logic [31:0] a, input logic [2:0] w, input logic s);
        ld_addr[ch*AW +: AW] = a;
        ld_width[ch*3 +: 3] = w;
        ld_sgn[ch] = s;
        ld_en[ch] = 1'b1;
    endtask

    task automatic wait_done(output int got, output logic [31:0] d);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (ld_done === '0 && k < 300);
        chk("load_done", k < 300, 1);
        got = -1;
        for (int i = 0; i < NL; i++) if (ld_done[i]) got = i;
        d = ld_data;
        ld_en = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; st_en = 1'b0; ld_en = '0; rob_rst = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        exp_wr.delete();
        foreach (mem[i]) refm[i] = mem[i];
        rr_m = 0;
    endtask

    task automatic t_table();
        int got;
        logic [31:0] d;
        txn_t t;
        for (int i = 0; i < 6; i++) begin
            log_q.delete();
            if (vt[i].st) begin
                push_store(vt[i].addr, vt[i].data, vt[i].width);
            end else begin
                if (vt[i].plant) begin
                    mem[vt[i].addr[9:2]] = vt[i].data;
                    refm[vt[i].addr[9:2]] = vt[i].data;
                end
                @(negedge clk);
                set_ld(vt[i].ch, vt[i].addr, vt[i].width, vt[i].sgn);
                wait_done(got, d);
                chk($sformatf("tbl%0d_ch", i), got, vt[i].ch);
                chk($sformatf("tbl%0d_ld_data", i), d, vt[i].exp_data);
            end
            wait_log(1, $sformatf("tbl%0d_txn", i));
            if (log_q.size() > 0) begin
                t = log_q[0];
                chk($sformatf("tbl%0d_rw", i), t.rw, vt[i].exp_rw);
                chk($sformatf("tbl%0d_addr", i), t.addr, vt[i].exp_addr);
                chk($sformatf("tbl%0d_width", i), t.width, vt[i].width);
                chk($sformatf("tbl%0d_sgn", i), t.sgn, vt[i].st ? 1'b0 : vt[i].sgn);
                chk($sformatf("tbl%0d_stable", i), t.stable, 1);
                if (vt[i].st) chk($sformatf("tbl%0d_wdata", i), t.data, vt[i].exp_data);
            end
        end
        exp_wr.delete();
    endtask

    task automatic t_fill();
        int idx, acks, k;
        idx = 0; acks = 0; k = 0;
        resp_on = 1'b0;
        log_q.delete();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (st_ack) acks++;
            st_en = 1'b1; st_addr = 32'h100 + 32'(idx) * 4; st_data = 32'hA0 + 32'(idx); st_width = 3'd2;
            if (!st_full) begin refm[st_addr[9:2]] = st_data; idx++; end
        end
        chk("fill_acks", acks, 4);
        chk("fill_full", st_full, 1);
        chk("fill_held", idx, 4);
        resp_on = 1'b1;
        lat = 0;
        while (st_full && k < 100) begin @(negedge clk); k++; end
        chk("fill_fifth_accept", k < 100, 1);
        refm[st_addr[9:2]] = st_data;
        @(negedge clk);
        st_en = 1'b0;
        wait_log(5, "fill_drain");
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk($sformatf("fill_order%0d", i), {log_q[i].rw, log_q[i].addr, log_q[i].data},
                {1'b1, 32'h100 + 32'(i) * 4, 32'hA0 + 32'(i)});
        end
    endtask

    task automatic t_reset_mid();
        bit saw_en;
        saw_en = 1'b0;
        resp_on = 1'b0;
        push_store(32'h200, 32'h11, 3'd2);
        push_store(32'h204, 32'h22, 3'd2);
        wait_en(1'b1, "rst_wdata_reached");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {ram_en, ram_rw, ram_sgn, ram_width, st_ack, ld_done}, '0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_ld_data", ld_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        resp_on = 1'b1;
        repeat (6) begin @(negedge clk); if (ram_en) saw_en = 1'b1; end
        chk("rst_fifo_empty", saw_en, 0);
        chk("rst_not_full", st_full, 0);
        log_q.delete();
        exp_wr.delete();
        foreach (mem[i]) refm[i] = mem[i];
    endtask

    task automatic t_rr();
        int n, k, exp_ch[3];
        exp_ch = '{0, 1, 0};
        n = 0; k = 0;
        apply_reset();
        lat = 2;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h08] = 32'h12345678;
        @(negedge clk);
        set_ld(0, 32'h10, 3'd2, 1'b0);
        set_ld(1, 32'h20, 3'd2, 1'b0);
        while (n < 3 && k < 300) begin
            @(negedge clk);
            k++;
            if (ld_done !== '0) begin
                chk($sformatf("rr_order%0d", n), ld_done, 2'b01 << exp_ch[n]);
                chk($sformatf("rr_data%0d", n), ld_data, exp_ch[n] == 0 ? 32'hDEADBEEF : 32'h12345678);
                n++;
                if (n == 3) ld_en = '0;
            end
        end
        chk("rr_count", n, 3);
    endtask

    task automatic t_flush();
        bit saw;
        saw = 1'b0;
        resp_on = 1'b0;
        log_q.delete();
        @(negedge clk);
        set_ld(0, 32'h30, 3'd2, 1'b0);
        wait_en(1'b0, "flush_rd_reached");
        @(negedge clk);
        rob_rst = 1'b1; ld_en = '0;
        @(negedge clk);
        rob_rst = 1'b0;
        chk("flush_rd_en_low", ram_en, 0);
        resp_on = 1'b1;
        repeat (5) begin @(negedge clk); if (ram_en || ld_done !== '0) saw = 1'b1; end
        chk("flush_rd_idle", saw, 0);
        chk("flush_rd_no_txn", log_q.size(), 0);
        resp_on = 1'b0;
        push_store(32'h300, 32'h5A5A, 3'd2);
        wait_en(1'b1, "flush_wr_reached");
        @(negedge clk);
        rob_rst = 1'b1;
        @(negedge clk);
        rob_rst = 1'b0;
        chk("flush_wr_hold", ram_en, 1);
        resp_on = 1'b1;
        wait_log(1, "flush_wr_done");
        if (log_q.size() > 0) chk("flush_wr_txn", {log_q[0].rw, log_q[0].addr, log_q[0].data}, {1'b1, 32'h300, 32'h5A5A});
        exp_wr.delete();
    endtask

    task automatic order_case(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d1,
                              input logic [31:0] la, input int ch, input bit rd_first, input string nm);
        int got;
        logic [31:0] d;
        resp_on = 1'b0;
        log_q.delete();
        push_store(a0, 32'h1111, 3'd2);
        push_store(a1, d1, 3'd2);
        @(negedge clk);
        set_ld(ch, la, 3'd2, 1'b0);
        repeat (2) @(negedge clk);
        lat = 1;
        resp_on = 1'b1;
        wait_done(got, d);
        chk({nm, "_ch"}, got, ch);
        chk({nm, "_data"}, d, refm[la[9:2]]);
        wait_log(3, {nm, "_txns"});
        if (log_q.size() >= 3) begin
            chk({nm, "_first"}, {log_q[0].rw, log_q[0].addr}, {1'b1, a0});
            chk({nm, "_second"}, {log_q[1].rw, log_q[1].addr}, rd_first ? {1'b0, la} : {1'b1, a1});
            chk({nm, "_third"}, {log_q[2].rw, log_q[2].addr}, rd_first ? {1'b1, a1} : {1'b0, la});
        end
        exp_wr.delete();
    endtask

    task automatic drain_log();
        txn_t t;
        while (log_q.size() > 0) begin
            t = log_q.pop_front();
            chk("rnd_stable", t.stable, 1);
            if (t.rw) begin
                chk("rnd_wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) chk("rnd_wr_order", {t.addr, t.data}, exp_wr.pop_front());
            end
        end
    endtask

    task automatic t_random();
        logic [NL-1:0] rem;
        logic [31:0] la [NL];
        int k, c, e;
        apply_reset();
        for (int ph = 0; ph < 40; ph++) begin
            lat = $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) push_store(32'($urandom_range(0, 15)) * 4, $urandom, 3'd2);
            rem = NL'($urandom_range(1, (1 << NL) - 1));
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                la[i] = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                if (rem[i]) set_ld(i, la[i], 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            end
            k = 0;
            while (rem != '0 && k < 400) begin
                @(negedge clk);
                k++;
                drain_log();
                if (ld_done !== '0) begin
                    c = -1;
                    for (int i = 0; i < NL; i++) if (ld_done[i]) c = i;
                    e = -1;
                    for (int j = NL - 1; j >= 0; j--) if (rem[(rr_m + j) % NL]) e = (rr_m + j) % NL;
`ifdef LD_BYPASS_EN
                    chk("rnd_ch_pending", (c >= 0) && rem[c], 1);
`else
                    chk("rnd_rr_order", c, e);
`endif
                    if (c >= 0) begin
                        chk("rnd_ld_data", ld_data, refm[la[c][9:2]]);
                        rem[c] = 1'b0;
                        ld_en[c] = 1'b0;
                        rr_m = (c + 1) % NL;
                    end
                end
            end
            chk("rnd_loads_done", rem, 0);
            k = 0;
            while (exp_wr.size() > 0 && k < 300) begin @(negedge clk); k++; drain_log(); end
            chk("rnd_writes_drained", exp_wr.size(), 0);
        end
    endtask

    initial begin
        foreach (mem[i]) begin mem[i] = 32'h5000_0000 + 32'(i) * 32'h0101; refm[i] = mem[i]; end
        vt[0] = '{1'b1, 0, 32'h40, 3'd2, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h40, 32'hDEADBEEF};
        vt[1] = '{1'b1, 0, 32'h44, 3'd0, 1'b0, 1'b0, 32'h000000A5, 1'b1, 32'h44, 32'h000000A5};
        vt[2] = '{1'b0, 0, 32'h80, 3'd2, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h80, 32'hCAFEF00D};
        vt[3] = '{1'b0, 1, 32'h86, 3'd1, 1'b1, 1'b1, 32'h0000FFFF, 1'b0, 32'h86, 32'h0000FFFF};
        vt[4] = '{1'b0, 1, 32'h40, 3'd2, 1'b0, 1'b0, 32'h0,        1'b0, 32'h40, 32'hDEADBEEF};
        vt[5] = '{1'b0, 0, 32'h44, 3'd4, 1'b1, 1'b0, 32'h0,        1'b0, 32'h44, 32'h000000A5};

        @(negedge clk);
        chk("reset_ram", {ram_en, ram_rw, ram_sgn, ram_width, ram_addr, ram_data}, '0);
        chk("reset_ld", {ld_done, ld_data}, '0);
        chk("reset_st", {st_full, st_ack}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b0;
        #1 chk("full_when_not_rdy", st_full, 1);
        rdy = 1'b1;
        #1 chk("not_full_when_rdy", st_full, 0);

        t_table();
        t_fill();
        t_reset_mid();
        t_rr();
        t_flush();
        order_case(32'h50, 32'h60, 32'h222, 32'h60, 1, 1'b0, "prio_same_word");
`ifdef LD_BYPASS_EN
        order_case(32'h300, 32'h200, 32'hBBBB, 32'h100, 0, 1'b1, "bypass_other_word");
`else
        order_case(32'h300, 32'h200, 32'hBBBB, 32'h100, 0, 1'b0, "stores_first");
`endif
        order_case(32'h300, 32'h100, 32'hCCCC, 32'h102, 0, 1'b0, "conflict_wait");
        t_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
